prio_arbiter: RTL and testbench

- Sequential 8-requester arbiter for a single shared resource.
- Picks one requester per arbitration, holds the grant until release or timeout, and inserts one dead cycle between grants.
- Fixed-priority mode uses the team's 8-to-3 encoding rule: req[7] highest, req[0] lowest, index output 3-bit binary.
- Round-robin mode rotates priority after each grant; sits between requesting masters and the shared datapath mux.

---
 rtl/prio_arbiter.sv | 65 ++++++
 tb/tb_prio_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// prio_arbiter: 8-requester arbiter with fixed/round-robin priority, hold timeout and one-cycle gap.
module prio_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rr_mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_hold;
  logic [2:0]       r_last;
  logic [2:0]       w_fix;
  logic [2:0]       w_rr;
  logic [2:0]       w_win;
  // Later loop iterations overwrite earlier ones, so the highest-priority hit wins.
  always_comb begin
    w_fix = '0;
    for (int k = 0; k < 8; k++)
      if (req[k]) w_fix = 3'(k);
    w_rr = r_last;
    for (int k = 8; k >= 1; k--)
      if (req[r_last - 3'(k)]) w_rr = r_last - 3'(k);
    w_win = rr_mode ? w_rr : w_fix;
  end
  // IDLE and GAP both arbitrate; GAP exists only to force the zero cycle after a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_last    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (r_state == GRANT) begin
        if (req[gnt_idx] && r_hold < CNT_W'(MAX_HOLD)) begin
          r_hold <= r_hold + 1'b1;
        end else begin
          gnt       <= '0;
          gnt_valid <= 1'b0;
          timeout   <= req[gnt_idx];
          r_state   <= GAP;
        end
      end else if (|req) begin
        gnt       <= 8'b1 << w_win;
        gnt_idx   <= w_win;
        gnt_valid <= 1'b1;
        r_last    <= w_win;
        r_hold    <= CNT_W'(1);
        r_state   <= GRANT;
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: directed and randomized checks of prio_arbiter against a behavioural model.
module tb_prio_arbiter;
  localparam int MH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic rr_mode = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic gnt_valid;
  logic timeout;
  logic [12:0] dut_vec;
  int errors = 0;
  int checks = 0;
  int m_owner, m_held, m_last;
  logic [2:0] m_idx;
  logic m_to;

  prio_arbiter #(.MAX_HOLD(MH), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_mode(rr_mode),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  assign dut_vec = {gnt, gnt_idx, gnt_valid, timeout};
  always #5 clk = ~clk;

  function automatic int pick(logic [7:0] r, logic rr, int last);
    if (!rr) begin
      for (int i = 7; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int d = 1; d <= 8; d++) if (r[(last - d + 8) % 8]) return (last - d + 8) % 8;
    end
    return -1;
  endfunction

  task m_reset;
    m_owner = -1; m_held = 0; m_last = 0; m_idx = 3'd0; m_to = 1'b0;
  endtask

  task m_step(input logic [7:0] r, input logic rr);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (r[m_owner] && m_held < MH) m_held++;
      else begin m_to = r[m_owner]; m_owner = -1; end
    end else if (r != 8'h00) begin
      m_owner = pick(r, rr, m_last);
      m_idx = 3'(m_owner);
      m_last = m_owner;
      m_held = 1;
    end
  endtask

  function automatic logic [12:0] m_vec();
    logic v;
    v = (m_owner >= 0);
    return {v ? 8'b1 << m_idx : 8'b0, m_idx, v, m_to};
  endfunction

  task tick;
    @(posedge clk);
    m_step(req, rr_mode);
    #1;
  endtask

  task do_reset;
    rst_n = 1'b0; m_reset(); #2; rst_n = 1'b1;
  endtask

  task test_reset;
    rst_n = 1'b0; req = 8'hFF; rr_mode = 1'b0; m_reset();
    #3;
    checks++; if (dut_vec !== 13'h0) begin errors++; $display("FAIL reset got=%h exp=%h", dut_vec, 13'h0); end
    @(negedge clk); rst_n = 1'b1;
    tick;
    checks++; if (dut_vec !== {8'h80, 3'd7, 1'b1, 1'b0}) begin errors++; $display("FAIL fixed_first got=%h exp=%h", dut_vec, {8'h80, 3'd7, 1'b1, 1'b0}); end
    checks++; if (dut_vec !== m_vec()) begin errors++; $display("FAIL fixed_first_model got=%h exp=%h", dut_vec, m_vec()); end
  endtask

  task test_release_gap;
    req = 8'h7F;
    tick;
    checks++; if (dut_vec !== {8'h00, 3'd7, 1'b0, 1'b0}) begin errors++; $display("FAIL gap got=%h exp=%h", dut_vec, {8'h00, 3'd7, 1'b0, 1'b0}); end
    tick;
    checks++; if (dut_vec !== {8'h40, 3'd6, 1'b1, 1'b0}) begin errors++; $display("FAIL after_gap got=%h exp=%h", dut_vec, {8'h40, 3'd6, 1'b1, 1'b0}); end
  endtask

  task test_timeout;
    int n;
    do_reset(); rr_mode = 1'b0; req = 8'h04;
    tick;
    n = 0;
    while (gnt == 8'h04 && n < 40) begin
      n++;
      checks++; if (dut_vec !== m_vec()) begin errors++; $display("FAIL timeout_model got=%h exp=%h", dut_vec, m_vec()); end
      tick;
    end
    checks++; if (n != MH) begin errors++; $display("FAIL hold_len got=%0d exp=%0d", n, MH); end
    checks++; if ({gnt, timeout} !== {8'h00, 1'b1}) begin errors++; $display("FAIL timeout_pulse got=%h exp=%h", {gnt, timeout}, {8'h00, 1'b1}); end
    tick;
    checks++; if (dut_vec !== {8'h04, 3'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL regrant got=%h exp=%h", dut_vec, {8'h04, 3'd2, 1'b1, 1'b0}); end
  endtask

  task test_rr_rotation;
    int cd[8];
    int order[$];
    int exp_o[6];
    logic prev;
    exp_o = '{5, 2, 0, 5, 2, 0};
    foreach (cd[i]) cd[i] = 0;
    prev = 1'b0;
    do_reset(); rr_mode = 1'b1; req = 8'h25;
    for (int c = 0; c < 80 && order.size() < 6; c++) begin
      tick;
      checks++; if (dut_vec !== m_vec()) begin errors++; $display("FAIL rr_model got=%h exp=%h", dut_vec, m_vec()); end
      if (gnt_valid && !prev) order.push_back(int'(gnt_idx));
      prev = gnt_valid;
      for (int i = 0; i < 8; i++)
        if (cd[i] > 0) begin cd[i]--; if (cd[i] == 0) req[i] = 1'b1; end
      if (gnt_valid && req[gnt_idx]) begin req[gnt_idx] = 1'b0; cd[gnt_idx] = 2; end
    end
    checks++; if (order.size() != 6) begin errors++; $display("FAIL rr_count got=%0d exp=6", order.size()); end
    for (int k = 0; k < order.size() && k < 6; k++) begin
      checks++; if (order[k] != exp_o[k]) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, order[k], exp_o[k]); end
    end
  endtask

  task test_rr_wrap;
    do_reset(); rr_mode = 1'b1; req = 8'h01;
    tick;
    checks++; if (dut_vec !== {8'h01, 3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_g0 got=%h exp=%h", dut_vec, {8'h01, 3'd0, 1'b1, 1'b0}); end
    req = 8'h00;
    tick;
    req = 8'h81;
    tick;
    checks++; if (dut_vec !== {8'h80, 3'd7, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_g7 got=%h exp=%h", dut_vec, {8'h80, 3'd7, 1'b1, 1'b0}); end
    req = 8'h01;
    tick;
    checks++; if (dut_vec !== {8'h00, 3'd7, 1'b0, 1'b0}) begin errors++; $display("FAIL wrap_gap got=%h exp=%h", dut_vec, {8'h00, 3'd7, 1'b0, 1'b0}); end
    tick;
    checks++; if (dut_vec !== {8'h01, 3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_back0 got=%h exp=%h", dut_vec, {8'h01, 3'd0, 1'b1, 1'b0}); end
  endtask

  task test_async_reset;
    do_reset(); rr_mode = 1'b0; req = 8'h08;
    tick;
    checks++; if (dut_vec !== {8'h08, 3'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL ar_grant got=%h exp=%h", dut_vec, {8'h08, 3'd3, 1'b1, 1'b0}); end
    tick;
    #2; rst_n = 1'b0; #1;
    checks++; if (dut_vec !== 13'h0) begin errors++; $display("FAIL ar_drop got=%h exp=%h", dut_vec, 13'h0); end
    m_reset(); #1; rst_n = 1'b1;
    tick;
    checks++; if (dut_vec !== {8'h08, 3'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL ar_regrant got=%h exp=%h", dut_vec, {8'h08, 3'd3, 1'b1, 1'b0}); end
  endtask

  task test_random;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) rr_mode = 1'($urandom);
      tick;
      checks++; if (dut_vec !== m_vec()) begin errors++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", c, dut_vec, m_vec()); end
      checks++; if (gnt !== (8'(gnt_valid) << gnt_idx)) begin errors++; $display("FAIL onehot cyc=%0d got=%h exp=%h", c, gnt, 8'(gnt_valid) << gnt_idx); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    m_reset();
    test_reset();
    test_release_gap();
    test_timeout();
    test_rr_rotation();
    test_rr_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
